// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg -- EX/MEM pipeline register of the 5-stage MIPS core.
//
// Captures the EX-stage result, store data, destination register, PC+8 and
// the MEM/WB control bits, and presents them to the data-memory stage.
// Handles debug-unit enable, hazard stall, flush (bubble insertion),
// misaligned-access suppression and halt propagation (RUN/HALTED).
//
// Ports
//   i_clock        system clock, rising edge
//   i_reset        asynchronous active-low reset
//   i_enable       debug-unit run/step enable; 0 freezes every register
//   i_stall        hazard stall; holds the current entry
//   i_flush        loads a bubble (wins over stall)
//   i_aluresult    EX result / data-memory address
//   i_datawrite    store data
//   i_regdest      destination register index
//   i_pc8          PC+8 link value
//   i_mem          [2] memread, [1] memwrite, [0] reserved
//   i_wb           [1] regwrite, [0] memtoreg
//   i_signedmem    sign-extend load
//   i_sizemem      00 byte, 01 half, 10/11 word
//   i_halt         HALT instruction present in EX
//   o_*            registered copies of the above (control gated)
//   o_misaligned   held entry is a misaligned memory access
//   o_halt         HALT has reached this stage
//   o_valid        held entry is a real instruction, not a bubble
// ---------------------------------------------------------------------------
module ex_mem_reg #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_ADDR   = 5
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_aluresult,
  input  logic [DATA_WIDTH-1:0] i_datawrite,
  input  logic [REG_ADDR-1:0]   i_regdest,
  input  logic [DATA_WIDTH-1:0] i_pc8,
  input  logic [2:0]            i_mem,
  input  logic [1:0]            i_wb,
  input  logic                  i_signedmem,
  input  logic [1:0]            i_sizemem,
  input  logic                  i_halt,
  output logic [DATA_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH-1:0] o_datawrite,
  output logic [REG_ADDR-1:0]   o_regdest,
  output logic [DATA_WIDTH-1:0] o_pc8,
  output logic [2:0]            o_mem,
  output logic [1:0]            o_wb,
  output logic                  o_signedmem,
  output logic [1:0]            o_sizemem,
  output logic                  o_misaligned,
  output logic                  o_halt,
  output logic                  o_valid
);

  localparam int unsigned MEM_W  = 3;
  localparam int unsigned WB_W   = 2;
  localparam int unsigned SIZE_W = 2;

  localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'b00;
  localparam logic [SIZE_W-1:0] SIZE_HALF = 2'b01;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  // Everything held by the stage for one instruction.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] datawrite;
    logic [REG_ADDR-1:0]   regdest;
    logic [DATA_WIDTH-1:0] pc8;
    logic [MEM_W-1:0]      mem;
    logic [WB_W-1:0]       wb;
    logic                  signedmem;
    logic [SIZE_W-1:0]     sizemem;
    logic                  misaligned;
    logic                  valid;
  } entry_t;

  state_e state_q, state_d;
  entry_t entry_q, entry_d;

  logic   mem_access_c;
  logic   size_mis_c;
  logic   mis_c;
  entry_t load_entry_c;

  // Alignment requirement of the incoming access size.
  always_comb begin
    size_mis_c = 1'b0;
    unique case (i_sizemem)
      SIZE_BYTE: size_mis_c = 1'b0;
      SIZE_HALF: size_mis_c = i_aluresult[0];
      default:   size_mis_c = |i_aluresult[1:0];
    endcase
  end

  assign mem_access_c = i_mem[2] | i_mem[1];
  assign mis_c        = mem_access_c & size_mis_c;

  // Entry captured on a normal load; control is squashed for a misaligned
  // access (no memory or register write) and for HALT (no side effects).
  always_comb begin
    load_entry_c            = '0;
    load_entry_c.address    = i_aluresult;
    load_entry_c.datawrite  = i_datawrite;
    load_entry_c.regdest    = i_regdest;
    load_entry_c.pc8        = i_pc8;
    load_entry_c.signedmem  = i_signedmem;
    load_entry_c.sizemem    = i_sizemem;
    load_entry_c.misaligned = mis_c;
    load_entry_c.valid      = 1'b1;
    load_entry_c.mem        = i_mem;
    load_entry_c.wb         = i_wb;
    if (mis_c) begin
      load_entry_c.mem[2:1] = 2'b00;
      load_entry_c.wb[1]    = 1'b0;
    end
    if (i_halt) begin
      load_entry_c.mem = '0;
      load_entry_c.wb  = '0;
    end
  end

  // Next-state / next-entry selection in update priority order:
  // enable, halted, flush, stall, load.
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    if (i_enable) begin
      if ((state_q == ST_HALTED) || i_flush) begin
        entry_d = '0;
      end else if (!i_stall) begin
        entry_d = load_entry_c;
        if (i_halt) begin
          state_d = ST_HALTED;
        end
      end
    end
  end

  // State and entry registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_RUN;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
    end
  end

  assign o_address    = entry_q.address;
  assign o_datawrite  = entry_q.datawrite;
  assign o_regdest    = entry_q.regdest;
  assign o_pc8        = entry_q.pc8;
  assign o_mem        = entry_q.mem;
  assign o_wb         = entry_q.wb;
  assign o_signedmem  = entry_q.signedmem;
  assign o_sizemem    = entry_q.sizemem;
  assign o_misaligned = entry_q.misaligned;
  assign o_valid      = entry_q.valid;
  // Halt flag is the state flop itself, so it is set in the same update as
  // the HALT entry and survives every later bubble until reset.
  assign o_halt       = (state_q == ST_HALTED);

endmodule

// File: tb/tb_ex_mem_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_reg -- scoreboard bench for ex_mem_reg.
// Stimulus is driven on the falling edge; the reference model computes the
// register contents expected after the next rising edge and queues them.
// The monitor samples 1 time unit after each rising edge and compares.
// ---------------------------------------------------------------------------
module tb_ex_mem_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned VW = 3*DW + RW + 3 + 2 + 1 + 2 + 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, stall, flush, halt, sgn;
  logic [DW-1:0] alu, dwr, pc8;
  logic [RW-1:0] rd;
  logic [2:0]    mem;
  logic [1:0]    wb, size;

  logic [DW-1:0] o_address, o_datawrite, o_pc8;
  logic [RW-1:0] o_regdest;
  logic [2:0]    o_mem;
  logic [1:0]    o_wb, o_sizemem;
  logic          o_signedmem, o_misaligned, o_halt, o_valid;

  always #5 clk = ~clk;

  ex_mem_reg #(.DATA_WIDTH(DW), .REG_ADDR(RW)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_stall(stall),
    .i_flush(flush), .i_aluresult(alu), .i_datawrite(dwr), .i_regdest(rd),
    .i_pc8(pc8), .i_mem(mem), .i_wb(wb), .i_signedmem(sgn),
    .i_sizemem(size), .i_halt(halt),
    .o_address(o_address), .o_datawrite(o_datawrite), .o_regdest(o_regdest),
    .o_pc8(o_pc8), .o_mem(o_mem), .o_wb(o_wb), .o_signedmem(o_signedmem),
    .o_sizemem(o_sizemem), .o_misaligned(o_misaligned), .o_halt(o_halt),
    .o_valid(o_valid)
  );

  logic [VW-1:0] dut_vec;
  assign dut_vec = {o_address, o_datawrite, o_regdest, o_pc8, o_mem, o_wb,
                    o_signedmem, o_sizemem, o_misaligned, o_halt, o_valid};

  // Reference model: what the stage should be holding.
  logic [DW-1:0] m_addr, m_dw, m_pc8;
  logic [RW-1:0] m_rd;
  logic [2:0]    m_mem;
  logic [1:0]    m_wb, m_size;
  logic          m_sgn, m_mis, m_halt, m_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [VW-1:0] exp_q[$];
  string         name_q[$];

  function automatic logic [VW-1:0] model_vec();
    return {m_addr, m_dw, m_rd, m_pc8, m_mem, m_wb, m_sgn, m_size,
            m_mis, m_halt, m_valid};
  endfunction

  task automatic check(input string nm, input logic [VW-1:0] act,
                       input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_addr = '0; m_dw = '0; m_rd = '0; m_pc8 = '0; m_mem = '0; m_wb = '0;
    m_sgn = 1'b0; m_size = '0; m_mis = 1'b0; m_valid = 1'b0;
  endtask

  // Effect of the coming rising edge given the current inputs.
  task automatic model_step();
    logic [1:0] lo;
    logic       is_mis;
    if (!rst_n) begin
      model_clear();
      m_halt = 1'b0;
    end else if (!en) begin
      // frozen
    end else if (m_halt || flush) begin
      model_clear();
    end else if (stall) begin
      // held
    end else begin
      lo = alu[1:0];
      is_mis = 1'b0;
      if (mem[2] || mem[1]) begin
        if (size == 2'd1) is_mis = lo[0];
        else if (size >= 2'd2) is_mis = (lo != 2'd0);
      end
      m_addr = alu; m_dw = dwr; m_rd = rd; m_pc8 = pc8;
      m_sgn = sgn; m_size = size; m_mis = is_mis; m_valid = 1'b1;
      if (halt) begin
        m_halt = 1'b1;
        m_mem = 3'd0;
        m_wb = 2'd0;
      end else begin
        m_mem = is_mis ? {2'b00, mem[0]} : mem;
        m_wb  = is_mis ? {1'b0, wb[0]} : wb;
      end
    end
  endtask

  task automatic drive(input logic e, input logic st, input logic fl,
                       input logic hl, input logic [DW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] p,
                       input logic [RW-1:0] r, input logic [2:0] m,
                       input logic [1:0] w, input logic sg,
                       input logic [1:0] sz, input string nm);
    en = e; stall = st; flush = fl; halt = hl; alu = a; dwr = d; pc8 = p;
    rd = r; mem = m; wb = w; sgn = sg; size = sz;
    model_step();
    exp_q.push_back(model_vec());
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  task automatic drive_rand(input logic e, input logic st, input logic fl,
                            input logic hl, input string nm);
    drive(e, st, fl, hl, $urandom, $urandom, $urandom, RW'($urandom),
          3'($urandom), 2'($urandom), 1'($urandom), 2'($urandom), nm);
  endtask

  // Reset asserted between edges must clear outputs immediately.
  task automatic async_reset(input string nm);
    #2 rst_n = 1'b0;
    #1 check(nm, dut_vec, '0);
    drive_rand(1'b1, 1'b0, 1'b0, 1'b0, {nm, "_held"});
    rst_n = 1'b1;
  endtask

  // Monitor: compare each queued expectation just after the rising edge.
  initial begin
    logic [VW-1:0] e;
    string         nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, dut_vec, e);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0; stall = 1'b0; flush = 1'b0; halt = 1'b0; sgn = 1'b0;
    alu = '0; dwr = '0; pc8 = '0; rd = '0; mem = '0; wb = '0; size = '0;
    model_clear();
    m_halt = 1'b0;
    #1 check("reset_state", dut_vec, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic load
    drive(1, 0, 0, 0, 32'h10, 32'hDEADBEEF, 32'h108, 5'd5, 3'b100, 2'b11,
          1'b0, 2'b10, "load_word");

    // Alignment cases
    drive(1, 0, 0, 0, 32'h6, 32'h1234, 32'h20, 5'd7, 3'b010, 2'b10, 1'b0,
          2'b10, "sw_mis_6");
    drive(1, 0, 0, 0, 32'h6, 32'h1234, 32'h20, 5'd7, 3'b010, 2'b10, 1'b0,
          2'b00, "sb_6");
    drive(1, 0, 0, 0, 32'h5, 32'h55, 32'h24, 5'd8, 3'b101, 2'b11, 1'b1,
          2'b01, "lh_mis_5");
    drive(1, 0, 0, 0, 32'h6, 32'h66, 32'h28, 5'd9, 3'b100, 2'b11, 1'b1,
          2'b01, "lh_6");
    drive(1, 0, 0, 0, 32'h3, 32'h77, 32'h2C, 5'd10, 3'b100, 2'b11, 1'b0,
          2'b11, "lw11_mis_3");
    drive(1, 0, 0, 0, 32'h3, 32'h77, 32'h2C, 5'd10, 3'b000, 2'b11, 1'b0,
          2'b10, "alu_unaligned");

    // Stall holds, flush beats stall
    drive(1, 0, 0, 0, 32'hA0, 32'hA1, 32'hA2, 5'd11, 3'b100, 2'b11, 1'b0,
          2'b10, "entry_A");
    for (int i = 0; i < 3; i++)
      drive_rand(1, 1, 0, 0, "stall_hold");
    drive_rand(1, 1, 1, 0, "stall_flush");

    // Enable low freezes, flush pulses ignored
    drive(1, 0, 0, 0, 32'hB0, 32'hB1, 32'hB2, 5'd12, 3'b010, 2'b00, 1'b0,
          2'b10, "entry_B");
    for (int i = 0; i < 4; i++)
      drive_rand(0, 0, 1'(i), 0, "enable_low");
    drive_rand(1, 0, 0, 0, "reenable");

    // HALT with flush: flush wins, stays RUN
    drive(1, 0, 1, 1, 32'hC0, 32'hC1, 32'hC2, 5'd13, 3'b100, 2'b11, 1'b0,
          2'b10, "halt_flush");
    drive_rand(1, 0, 0, 0, "after_halt_flush");

    // Randomised traffic without HALT
    for (int i = 0; i < 300; i++)
      drive_rand(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 9) == 0), 1'b0, "rand_run");

    // HALT entry, then bubbles, holds, async reset, resume
    drive(1, 0, 0, 1, 32'hD0, 32'hD1, 32'hD2, 5'd14, 3'b000, 2'b11, 1'b1,
          2'b10, "halt_load");
    for (int i = 0; i < 5; i++)
      drive_rand(1, 0, 0, 0, "halted_bubble");
    drive_rand(1, 1, 0, 0, "halted_stall");
    drive_rand(0, 0, 0, 0, "halted_disabled");
    async_reset("async_reset");
    drive(1, 0, 0, 0, 32'hE0, 32'hE1, 32'hE2, 5'd15, 3'b100, 2'b11, 1'b0,
          2'b10, "resume_load");

    // Randomised traffic including HALT and periodic reset
    for (int i = 0; i < 400; i++) begin
      if (i % 60 == 59) async_reset("rand_reset");
      drive_rand(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 29) == 0),
                 "rand_halt");
    end

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
